// File: rtl/iob_2p_assim_fifo_ctrl_pkg.sv
// Shared types and helpers for the
// width-converting FIFO controller.
package iob_2p_assim_fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    LVL_HOLD = 2'b00,
    LVL_POP  = 2'b01,
    LVL_PUSH = 2'b10,
    LVL_BOTH = 2'b11
  } lvl_op_e;

  function automatic int ratio_f(
    input int w,
    input int r
  );
    return w / r;
  endfunction

  function automatic int depth_f(
    input int aw
  );
    return 1 << aw;
  endfunction

  function automatic lvl_op_e lvl_op(
    input logic push,
    input logic pop
  );
    return lvl_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/iob_fifo_level_cnt.sv
// Occupancy counter in narrow words:
// up by RATIO on push, down by 1 on pop.
module iob_fifo_level_cnt
  import iob_2p_assim_fifo_ctrl_pkg::*;
#(
  parameter int R_ADDR_W = 7,
  parameter int RATIO    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  output logic [R_ADDR_W:0] level_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int LVL_W = R_ADDR_W + 1;
  localparam int DEPTH = depth_f(R_ADDR_W);

  localparam logic [LVL_W-1:0] INC =
    LVL_W'(RATIO);
  localparam logic [LVL_W-1:0] INC_M1 =
    LVL_W'(RATIO - 1);
  localparam logic [LVL_W-1:0] THR =
    LVL_W'(DEPTH - RATIO);

  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;

  // next level from the accepted push/pop pair
  always_comb begin
    level_d = level_q;
    case (lvl_op(push_i, pop_i))
      LVL_PUSH: level_d = level_q + INC;
      LVL_POP:  level_d = level_q - 1'b1;
      LVL_BOTH: level_d = level_q + INC_M1;
      default:  level_d = level_q;
    endcase
  end

  // level register
  always_ff @(posedge clk) begin
    if (rst) level_q <= '0;
    else     level_q <= level_d;
  end

  assign level_o = level_q;
  assign empty_o = (level_q == '0);
  assign full_o  = (level_q > THR);

endmodule

// File: rtl/iob_2p_assim_fifo_ctrl.sv
// Wide-write / narrow-read FIFO controller
// driving an external two-port RAM.
module iob_2p_assim_fifo_ctrl
  import iob_2p_assim_fifo_ctrl_pkg::*;
#(
  parameter int W_DATA_W = 16,
  parameter int R_DATA_W = 8,
  parameter int W_ADDR_W = 6,
  parameter int R_ADDR_W = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_req,
  input  logic [W_DATA_W-1:0] w_data,
  output logic                full,
  input  logic                r_req,
  output logic [R_DATA_W-1:0] r_data,
  output logic                r_valid,
  output logic                empty,
  output logic [R_ADDR_W:0]   level,
  output logic                err_ovf,
  output logic                err_udf,
  output logic                mem_w_en,
  output logic [W_ADDR_W-1:0] mem_w_addr,
  output logic [W_DATA_W-1:0] mem_w_data,
  output logic                mem_r_en,
  output logic [R_ADDR_W-1:0] mem_r_addr,
  input  logic [R_DATA_W-1:0] mem_r_data
);

  localparam int RATIO =
    ratio_f(W_DATA_W, R_DATA_W);

  logic [W_ADDR_W-1:0] wptr_q, wptr_d;
  logic [R_ADDR_W-1:0] rptr_q, rptr_d;
  logic                r_valid_q;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;
  logic                push_ok;
  logic                pop_ok;

  // flags come from the level register, so
  // a same-cycle push never unblocks a pop
  assign push_ok = w_req & ~full & ~rst;
  assign pop_ok  = r_req & ~empty & ~rst;

  iob_fifo_level_cnt #(
    .R_ADDR_W (R_ADDR_W),
    .RATIO    (RATIO)
  ) u_lvl (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_ok),
    .pop_i   (pop_ok),
    .level_o (level),
    .empty_o (empty),
    .full_o  (full)
  );

  // pointer advance and sticky error capture
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q | (w_req & full);
    udf_d  = udf_q | (r_req & empty);
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop_ok)  rptr_d = rptr_q + 1'b1;
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      r_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      r_valid_q <= pop_ok;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  assign mem_w_en   = push_ok;
  assign mem_w_addr = wptr_q;
  assign mem_w_data = w_data;
  assign mem_r_en   = pop_ok;
  assign mem_r_addr = rptr_q;

  assign r_data  = mem_r_data;
  assign r_valid = r_valid_q;
  assign err_ovf = ovf_q;
  assign err_udf = udf_q;

endmodule

// File: tb/tb_iob_2p_assim_fifo_ctrl.sv
// Bench for iob_2p_assim_fifo_ctrl with a
// byte-queue reference model and RAM model.
module tb_iob_2p_assim_fifo_ctrl;

  logic        clk;
  logic        rst;
  logic        w_req;
  logic [15:0] w_data;
  logic        full;
  logic        r_req;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        empty;
  logic [7:0]  level;
  logic        err_ovf;
  logic        err_udf;
  logic        mem_w_en;
  logic [5:0]  mem_w_addr;
  logic [15:0] mem_w_data;
  logic        mem_r_en;
  logic [6:0]  mem_r_addr;
  logic [7:0]  mem_r_data;

  iob_2p_assim_fifo_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .w_req      (w_req),
    .w_data     (w_data),
    .full       (full),
    .r_req      (r_req),
    .r_data     (r_data),
    .r_valid    (r_valid),
    .empty      (empty),
    .level      (level),
    .err_ovf    (err_ovf),
    .err_udf    (err_udf),
    .mem_w_en   (mem_w_en),
    .mem_w_addr (mem_w_addr),
    .mem_w_data (mem_w_data),
    .mem_r_en   (mem_r_en),
    .mem_r_addr (mem_r_addr),
    .mem_r_data (mem_r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // wide-write narrow-read RAM, LSB slice at even address
  logic [7:0] ram [128];
  always @(posedge clk) begin
    if (mem_r_en) mem_r_data <= ram[mem_r_addr];
    if (mem_w_en) begin
      ram[{mem_w_addr, 1'b0}] <= mem_w_data[7:0];
      ram[{mem_w_addr, 1'b1}] <= mem_w_data[15:8];
    end
  end

  int errors = 0;
  int checks = 0;
  bit chk_on = 0;

  task automatic chk(
    input string       n,
    input logic [31:0] a,
    input logic [31:0] e
  );
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               n, a, e);
    end
  endtask

  // reference model: FIFO of narrow bytes
  logic [7:0] q[$];
  int  m_wp  = 0;
  int  m_rp  = 0;
  bit  m_ovf = 0;
  bit  m_udf = 0;
  bit  m_rv  = 0;
  logic [7:0] m_rd = 8'h00;

  // compare process: checks every cycle,
  // then advances the model past the edge
  always @(negedge clk) begin
    #3;
    if (chk_on) begin
      bit f, e, pa, pp;
      f  = q.size() > 126;
      e  = q.size() == 0;
      pa = !rst && w_req && !f;
      pp = !rst && r_req && !e;
      chk("level", 32'(level), 32'(q.size()));
      chk("full", 32'(full), 32'(f));
      chk("empty", 32'(empty), 32'(e));
      chk("mem_w_en", 32'(mem_w_en), 32'(pa));
      chk("mem_r_en", 32'(mem_r_en), 32'(pp));
      if (pa) begin
        chk("mem_w_addr", 32'(mem_w_addr),
            32'(m_wp % 64));
        chk("mem_w_data", 32'(mem_w_data),
            32'(w_data));
      end
      if (pp)
        chk("mem_r_addr", 32'(mem_r_addr),
            32'(m_rp % 128));
      chk("r_valid", 32'(r_valid), 32'(m_rv));
      if (m_rv)
        chk("r_data", 32'(r_data), 32'(m_rd));
      chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
      chk("err_udf", 32'(err_udf), 32'(m_udf));
      if (rst) begin
        q.delete();
        m_wp = 0; m_rp = 0;
        m_ovf = 0; m_udf = 0; m_rv = 0;
      end else begin
        m_rv = pp;
        if (pp) begin
          m_rd = q.pop_front();
          m_rp++;
        end
        if (pa) begin
          q.push_back(w_data[7:0]);
          q.push_back(w_data[15:8]);
          m_wp++;
        end
        if (w_req && f) m_ovf = 1;
        if (r_req && e) m_udf = 1;
      end
    end
  end

  // apply inputs after negedge, return just
  // before the next posedge
  task automatic drive(
    input bit          w,
    input logic [15:0] d,
    input bit          r,
    input bit          rs
  );
    @(negedge clk);
    w_req  = w;
    w_data = d;
    r_req  = r;
    rst    = rs;
    #4;
  endtask

  task automatic idle();
    drive(0, 16'h0, 0, 0);
  endtask

  initial begin
    logic [7:0] b;
    bit w, r;
    int n;
    rst = 1; w_req = 0; r_req = 0;
    w_data = '0;
    drive(0, 16'h0, 0, 1);
    chk_on = 1;
    drive(1, 16'hFFFF, 1, 1);
    idle();
    chk("rst level", 32'(level), 0);
    chk("rst empty", 32'(empty), 1);
    chk("rst full", 32'(full), 0);
    chk("rst r_valid", 32'(r_valid), 0);
    chk("rst errs", 32'({err_ovf, err_udf}), 0);
    chk("rst mem en",
        32'({mem_w_en, mem_r_en}), 0);

    drive(1, 16'hA1B2, 0, 0);
    chk("ord wen", 32'(mem_w_en), 1);
    idle();
    chk("ord lvl2", 32'(level), 2);
    drive(0, 16'h0, 1, 0);
    chk("ord ren", 32'(mem_r_en), 1);
    drive(0, 16'h0, 1, 0);
    chk("ord rv1", 32'(r_valid), 1);
    chk("ord rd1", 32'(r_data), 32'h B2);
    chk("ord lvl1", 32'(level), 1);
    idle();
    chk("ord rv2", 32'(r_valid), 1);
    chk("ord rd2", 32'(r_data), 32'h A1);
    chk("ord lvl0", 32'(level), 0);
    chk("ord empty", 32'(empty), 1);
    idle();
    chk("ord rv off", 32'(r_valid), 0);

    for (int i = 0; i < 64; i++)
      drive(1, 16'(i * 257 + 3), 0, 0);
    idle();
    chk("fill lvl", 32'(level), 128);
    chk("fill full", 32'(full), 1);
    drive(1, 16'hDEAD, 0, 0);
    chk("ovf wen", 32'(mem_w_en), 0);
    idle();
    chk("ovf flag", 32'(err_ovf), 1);
    chk("ovf lvl", 32'(level), 128);
    drive(0, 16'h0, 1, 0);
    idle();
    chk("pop1 lvl", 32'(level), 127);
    chk("pop1 full", 32'(full), 1);
    n = 0;
    while (q.size() > 0 && n < 200) begin
      drive(0, 16'h0, 1, 0);
      n++;
    end
    idle();
    chk("drain empty", 32'(empty), 1);

    drive(0, 16'h0, 0, 1);
    idle();
    drive(0, 16'h0, 1, 0);
    chk("udf ren", 32'(mem_r_en), 0);
    idle();
    chk("udf rv", 32'(r_valid), 0);
    chk("udf flag", 32'(err_udf), 1);
    drive(1, 16'h5566, 1, 0);
    chk("pp0 ren", 32'(mem_r_en), 0);
    chk("pp0 wen", 32'(mem_w_en), 1);
    idle();
    chk("pp0 lvl", 32'(level), 2);
    chk("pp0 rv", 32'(r_valid), 0);

    drive(0, 16'h0, 0, 1);
    b = 8'h00;
    for (int i = 0; i < 300; i++) begin
      w = ($urandom_range(1, 0) == 1) &&
          (q.size() <= 126);
      r = ($urandom_range(2, 0) != 0) &&
          (q.size() > 0);
      drive(w, {b + 8'd1, b}, r, 0);
      if (w) b = b + 8'd2;
    end
    idle();
    chk("wrap ovf", 32'(err_ovf), 0);
    chk("wrap udf", 32'(err_udf), 0);

    drive(0, 16'h0, 0, 1);
    for (int i = 0; i < 5; i++)
      drive(1, 16'(16'h0F00 + i), 0, 0);
    idle();
    chk("mid lvl10", 32'(level), 10);
    drive(0, 16'h0, 1, 1);
    chk("mid ren", 32'(mem_r_en), 0);
    idle();
    chk("mid lvl", 32'(level), 0);
    chk("mid empty", 32'(empty), 1);
    chk("mid rv", 32'(r_valid), 0);
    drive(1, 16'h1234, 0, 0);
    drive(0, 16'h0, 1, 0);
    drive(0, 16'h0, 1, 0);
    chk("mid rd1", 32'(r_data), 32'h34);
    chk("mid rv1", 32'(r_valid), 1);
    idle();
    chk("mid rd2", 32'(r_data), 32'h12);
    chk("mid rv2", 32'(r_valid), 1);
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
